// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the ram_sdp_be storage primitive.
//   BYTE_W          width of one byte lane
//   RDW_READ_FIRST  same-address read returns the pre-write word
//   RDW_WRITE_FIRST same-address read returns the merged (bypassed) word
//   state_t         init-sweep FSM states
//   parity()        even-parity bit of one byte
package ram_pkg;

  localparam int BYTE_W          = 8;
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit that makes {b, parity(b)} contain an even number of ones.
  function automatic logic parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_init_sweep.sv
// ram_init_sweep: post-reset initialisation sequencer for ram_sdp_be.
// After reset releases it writes INIT_VALUE to every address 0..DEPTH-1,
// one word per cycle, then parks in RUN until the next reset.
// Ports:
//   clk        clock, posedge
//   rst        asynchronous active-high reset, restarts the sweep
//   init_busy  high while the sweep runs (registered)
//   init_we    write strobe for the sweep (all lanes)
//   init_addr  address being initialised
//   init_data  value being written (INIT_VALUE)
module ram_init_sweep
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic [DATA_WIDTH-1:0] init_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
          state     <= RUN;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= INIT;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign init_we   = init_busy;
  assign init_addr = cnt;
  assign init_data = INIT_VALUE;

endmodule

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple dual-port RAM with byte enables, read latency 1 or 2,
// selectable same-address read-during-write policy and a hardware init sweep.
// Optional feature macro: RAM_SDP_PARITY_EN (per-lane even parity, adds
// par_inject input and parity_err output).
// Ports:
//   clk, rst             clock (posedge) / async active-high reset
//   init_busy            high during the init sweep; ports ignored meanwhile
//   wr_en/addr/data/be   write port with per-byte enables
//   rd_en/addr           read request
//   rd_data/rd_valid     read result (held) and one-cycle valid pulse
//   par_inject           (parity build) corrupt stored parity of written lanes
//   parity_err           (parity build) read word failed parity, with rd_valid
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    RD_LATENCY = 1,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_busy,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/BYTE_W-1:0] wr_be,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
`ifdef RAM_SDP_PARITY_EN
  input  logic                         par_inject,
  output logic                         parity_err,
`endif
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_W;

  if (DATA_WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("ram_sdp_be: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_be: RD_LATENCY must be 1 or 2");
  end

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] init_data;

  ram_init_sweep #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_sweep (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef RAM_SDP_PARITY_EN
  logic [NB-1:0]         pmem [DEPTH];
  logic [NB-1:0]         mem_pbit_p0;
  logic                  perr_p0;
  logic                  perr_p1;
`endif

  // ---- stage p0: port arbitration, array access, collision merge ----
  logic                  wr_fire_p0;
  logic                  rd_fire_p0;
  logic                  mem_we_p0;
  logic [ADDR_WIDTH-1:0] mem_waddr_p0;
  logic [DATA_WIDTH-1:0] mem_wdata_p0;
  logic [NB-1:0]         mem_be_p0;
  logic                  bypass_p0;
  logic [DATA_WIDTH-1:0] rd_word_p0;

  assign wr_fire_p0 = wr_en & ~init_busy;
  assign rd_fire_p0 = rd_en & ~init_busy;

  always_comb begin
    mem_we_p0    = init_we | wr_fire_p0;
    mem_waddr_p0 = init_we ? init_addr : wr_addr;
    mem_wdata_p0 = init_we ? init_data : wr_data;
    mem_be_p0    = init_we ? '1 : wr_be;
`ifdef RAM_SDP_PARITY_EN
    for (int i = 0; i < NB; i++) begin
      mem_pbit_p0[i] = parity(mem_wdata_p0[i*BYTE_W +: BYTE_W]) ^ (par_inject & wr_fire_p0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we_p0) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be_p0[i]) begin
          mem[mem_waddr_p0][i*BYTE_W +: BYTE_W] <= mem_wdata_p0[i*BYTE_W +: BYTE_W];
`ifdef RAM_SDP_PARITY_EN
          pmem[mem_waddr_p0][i] <= mem_pbit_p0[i];
`endif
        end
      end
    end
  end

  // The collision is resolved here, at the sampling edge, so a write that
  // lands while a latency-2 read is in flight cannot disturb it.
  assign bypass_p0 = (RDW_MODE == RDW_WRITE_FIRST) && wr_fire_p0 && (wr_addr == rd_addr);

  always_comb begin
    rd_word_p0 = mem[rd_addr];
`ifdef RAM_SDP_PARITY_EN
    perr_p0 = 1'b0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (bypass_p0 && wr_be[i]) begin
        // Fresh lane with freshly computed parity can never fail the check.
        rd_word_p0[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
      end else begin
`ifdef RAM_SDP_PARITY_EN
        perr_p0 = perr_p0 | (parity(rd_word_p0[i*BYTE_W +: BYTE_W]) ^ pmem[rd_addr][i]);
`endif
      end
    end
  end

  // ---- stage p1: optional extra read register, then output register ----
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef RAM_SDP_PARITY_EN
      perr_p1    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      vld_p1 <= rd_fire_p0;
      if (rd_fire_p0) begin
        data_p1 <= rd_word_p0;
`ifdef RAM_SDP_PARITY_EN
        perr_p1 <= perr_p0;
`endif
      end
      if (RD_LATENCY == 1) begin
        rd_valid <= rd_fire_p0;
        if (rd_fire_p0) begin
          rd_data <= rd_word_p0;
`ifdef RAM_SDP_PARITY_EN
          parity_err <= perr_p0;
`endif
        end
      end else begin
        rd_valid <= vld_p1;
        if (vld_p1) begin
          rd_data <= data_p1;
`ifdef RAM_SDP_PARITY_EN
          parity_err <= perr_p1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
module tb_ram_sdp_be;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          busy_a, busy_b, rdv_a, rdv_b;
  logic [DW-1:0] rdd_a, rdd_b;
`ifdef RAM_SDP_PARITY_EN
  logic          par_inject;
  logic          perr_a, perr_b;
`endif

  always #5 clk = ~clk;

  // Instance A: latency 1, read-first. Instance B: latency 2, write-first.
  ram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .RDW_MODE(0),
               .INIT_VALUE('0)) dut_a (
    .clk(clk), .rst(rst), .init_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef RAM_SDP_PARITY_EN
    .par_inject(par_inject), .parity_err(perr_a),
`endif
    .rd_data(rdd_a), .rd_valid(rdv_a));

  ram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .RDW_MODE(1),
               .INIT_VALUE('0)) dut_b (
    .clk(clk), .rst(rst), .init_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef RAM_SDP_PARITY_EN
    .par_inject(par_inject), .parity_err(perr_b),
`endif
    .rd_data(rdd_b), .rd_valid(rdv_b));

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    int            due;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] rf;   // expected on A (read-first)
    logic [DW-1:0] wf;   // expected on B (write-first)
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every rd_valid must match the oldest pending read,
  // on the exact cycle it is due; a due read with no rd_valid is a miss.
  always @(negedge clk) begin
    exp_t e;
    if (rdv_a) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL A_stray_valid: got rd_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = qa.pop_front();
        check("A_latency", cyc, e.due);
        check("A_data", rdd_a, e.data);
`ifdef RAM_SDP_PARITY_EN
        check("A_parity_err", {31'd0, perr_a}, {31'd0, e.perr});
`endif
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      n_cmp++; n_err++;
      $display("FAIL A_missing_valid: got rd_valid=0, expected 1 (cycle %0d)", cyc);
      void'(qa.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdv_b) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL B_stray_valid: got rd_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = qb.pop_front();
        check("B_latency", cyc, e.due);
        check("B_data", rdd_b, e.data);
`ifdef RAM_SDP_PARITY_EN
        check("B_parity_err", {31'd0, perr_b}, {31'd0, e.perr});
`endif
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      n_cmp++; n_err++;
      $display("FAIL B_missing_valid: got rd_valid=0, expected 1 (cycle %0d)", cyc);
      void'(qb.pop_front());
    end
  end

  // One cycle of stimulus; reads queue their expected results for both DUTs.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra,
                       input logic [DW-1:0] rf, input logic [DW-1:0] wf,
                       input logic perr, input logic pi);
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
`ifdef RAM_SDP_PARITY_EN
    par_inject = pi;
`endif
    if (re) begin
      qa.push_back('{data: rf, perr: perr, due: cyc + 1});
      qb.push_back('{data: wf, perr: perr, due: cyc + 2});
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Release reset and count posedges until init_busy drops.
  task automatic sweep_check(input string name);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    while (busy_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, 16);
    check({name, "_b"}, {31'd0, busy_b}, 32'd0);
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 1'b1, 4'd3,  32'h00000000, 32'hAABBCCDD};
    tbl[1]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 1'b1, 4'd3,  32'hAABBCCDD, 32'hAA22CC44};
    tbl[2]  = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd3,  32'hAA22CC44, 32'hAA22CC44};
    tbl[3]  = '{1'b1, 4'd1,  32'h01010101, 4'hF, 1'b1, 4'd0,  32'h00000000, 32'h00000000};
    tbl[4]  = '{1'b1, 4'd7,  32'h00000010, 4'hF, 1'b1, 4'd2,  32'h00000000, 32'h00000000};
    tbl[5]  = '{1'b1, 4'd7,  32'h00000055, 4'hF, 1'b1, 4'd7,  32'h00000010, 32'h00000055};
    tbl[6]  = '{1'b1, 4'd7,  32'h00000077, 4'hF, 1'b1, 4'd1,  32'h01010101, 32'h01010101};
    tbl[7]  = '{1'b1, 4'd2,  32'h02020202, 4'hF, 1'b0, 4'd2,  32'h00000000, 32'h00000000};
    tbl[8]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'h0, 1'b1, 4'd1,  32'h01010101, 32'h01010101};
    tbl[9]  = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd2,  32'h02020202, 32'h02020202};
    tbl[10] = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'h0, 1'b1, 4'd3,  32'hAA22CC44, 32'hAA22CC44};
    tbl[11] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd7,  32'h00000077, 32'h00000077};
    tbl[12] = '{1'b1, 4'd5,  32'hDEADBEEF, 4'h8, 1'b1, 4'd5,  32'h00000000, 32'hDE000000};
    tbl[13] = '{1'b1, 4'd9,  32'hCAFEF00D, 4'hF, 1'b1, 4'd5,  32'hDE000000, 32'hDE000000};
    tbl[14] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd9,  32'hCAFEF00D, 32'hCAFEF00D};
    tbl[15] = '{1'b1, 4'd15, 32'h12345678, 4'h3, 1'b1, 4'd15, 32'h00000000, 32'h00005678};
    tbl[16] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd15, 32'h00005678, 32'h00005678};

    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
`ifdef RAM_SDP_PARITY_EN
    par_inject = 1'b0;
`endif
    #12;
    check("reset_busy_a",  {31'd0, busy_a}, 32'd1);
    check("reset_busy_b",  {31'd0, busy_b}, 32'd1);
    check("reset_valid_a", {31'd0, rdv_a},  32'd0);
    check("reset_valid_b", {31'd0, rdv_b},  32'd0);
    check("reset_data_a",  rdd_a, 32'd0);
    check("reset_data_b",  rdd_b, 32'd0);

    // Requests held during the sweep must be ignored.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd0;
    sweep_check("init_sweep_len");
    wr_en = 1'b0; rd_en = 1'b0;

    for (int i = 0; i < 16; i++)
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i), 32'd0, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++)
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra,
            tbl[i].rf, tbl[i].wf, 1'b0, 1'b0);
    repeat (4) idle();
    check("hold_data_a", rdd_a, 32'h00005678);
    check("hold_data_b", rdd_b, 32'h00005678);

`ifdef RAM_SDP_PARITY_EN
    drive(1'b1, 4'd4, 32'h0000003C, 4'hF, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd4, 32'h0000003C, 32'h0000003C, 1'b1, 1'b0);
    drive(1'b1, 4'd4, 32'h0000003C, 4'hF, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd4, 32'h0000003C, 32'h0000003C, 1'b0, 1'b0);
    repeat (4) idle();
`endif

    // Reset while a latency-2 read is still in flight on B.
    drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 1'b0);
    @(posedge clk);
    #6;
    rst = 1'b1;
    rd_en = 1'b0;
    qb.delete();
    #1;
    check("midread_valid_b", {31'd0, rdv_b}, 32'd0);
    check("midread_busy_a",  {31'd0, busy_a}, 32'd1);
    check("midread_data_a",  rdd_a, 32'd0);

    // Reset five cycles into the sweep, then a full sweep must follow.
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("midsweep_busy", {31'd0, busy_a}, 32'd1);
    rst = 1'b1;
    sweep_check("resweep_len");

    drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (4) idle();

    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
    if (qa.size() > 0 || qb.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: got %0d/%0d pending reads, expected 0", qa.size(), qb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
